ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO operations with register operands. Owns the architectural HI/LO registers.
- Asserts busy so the hazard unit stalls the ID/EX register and holds any younger MFHI/MFLO or muldiv op until HI/LO are valid.

---
 rtl/ex_muldiv_unit_pkg.sv | 21 ++
 rtl/muldiv_sign_fix.sv | 28 ++
 rtl/ex_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared EX-stage multiply/divide definitions: operand width, op encodings
// and the controller state enum.
package ex_muldiv_unit_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 5;

   // Decoded muldiv operation codes presented on op
   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign correction for the muldiv datapath. On the operand
// side the two 32-bit halves are negated independently (absolute value of
// rs/rt); on the result side either the whole 64-bit product is negated or
// the quotient/remainder halves are negated independently.
module muldiv_sign_fix
   import ex_muldiv_unit_pkg::*;
(
   input  logic [2*DATA_W-1:0] val,
   input  logic                neg_full,
   input  logic                neg_hi,
   input  logic                neg_lo,
   output logic [2*DATA_W-1:0] res
);

   // Full-width negate takes priority; otherwise each half is handled alone
   always_comb begin
      res = val;
      if (neg_full) begin
         res = -val;
      end else begin
         if (neg_hi)
            res[2*DATA_W-1:DATA_W] = -val[2*DATA_W-1:DATA_W];
         if (neg_lo)
            res[DATA_W-1:0] = -val[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One radix-2 step per RUN cycle; 32 RUN cycles per MULT/DIV.
// Optional build macro MULDIV_EARLY_OUT_EN: a multiply commits as soon as
// the remaining multiplier bits are all zero (minimum one RUN cycle).
module ex_muldiv_unit #(
   parameter int DATA_W = ex_muldiv_unit_pkg::DATA_W,
   parameter int CNT_W  = ex_muldiv_unit_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   import ex_muldiv_unit_pkg::*;

   md_state_t         state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              is_div_reg;
   logic              neg_res_reg;   // result (product / quotient) negative
   logic              neg_rem_reg;   // remainder takes the dividend's sign
   logic              done_reg;
   logic [63:0]       acc_reg;       // product, or {remainder, quotient}
   logic [63:0]       mcand_reg;     // shifting multiplicand, or divisor in [31:0]
   logic [31:0]       mplier_reg;    // multiplier bits still to consume
   logic [31:0]       hi_reg;
   logic [31:0]       lo_reg;

   logic              op_signed;
   logic [63:0]       opnd_abs;      // {|rt|, |rs|}
   logic [63:0]       mul_sum;
   logic [32:0]       div_top;
   logic              div_ge;
   logic [63:0]       div_next;
   logic [63:0]       acc_next;
   logic [63:0]       res_fixed;
   logic              last_step;

   assign op_signed = (op == MD_MULT) || (op == MD_DIV);

   muldiv_sign_fix u_opnd_fix (
      .val      ({rt_val, rs_val}),
      .neg_full (1'b0),
      .neg_hi   (op_signed & rt_val[31]),
      .neg_lo   (op_signed & rs_val[31]),
      .res      (opnd_abs)
   );

   // One iteration step: shift-add multiply or restoring shift-subtract divide
   always_comb begin
      mul_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : 64'd0);
      div_top  = acc_reg[63:31];
      div_ge   = (div_top >= {1'b0, mcand_reg[31:0]});
      if (div_ge)
         div_next = {div_top[31:0] - mcand_reg[31:0], acc_reg[30:0], 1'b1};
      else
         div_next = {div_top[31:0], acc_reg[30:0], 1'b0};
      acc_next = is_div_reg ? div_next : mul_sum;
   end

   muldiv_sign_fix u_res_fix (
      .val      (acc_next),
      .neg_full (~is_div_reg & neg_res_reg),
      .neg_hi   (is_div_reg & neg_rem_reg),
      .neg_lo   (is_div_reg & neg_res_reg),
      .res      (res_fixed)
   );

`ifdef MULDIV_EARLY_OUT_EN
   assign last_step = (cnt_reg == '1) || (!is_div_reg && (mplier_reg[31:1] == 31'd0));
`else
   assign last_step = (cnt_reg == '1);
`endif

   // Controller, datapath registers and HI/LO commit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= MD_IDLE;
         cnt_reg     <= '0;
         is_div_reg  <= 1'b0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         done_reg    <= 1'b0;
         acc_reg     <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            MD_IDLE: begin
               if (start) begin
                  case (op)
                     MD_MTHI: hi_reg <= rs_val;
                     MD_MTLO: lo_reg <= rs_val;
                     MD_MULT, MD_MULTU: begin
                        acc_reg     <= '0;
                        mcand_reg   <= {32'd0, opnd_abs[31:0]};
                        mplier_reg  <= opnd_abs[63:32];
                        is_div_reg  <= 1'b0;
                        neg_res_reg <= op_signed & (rs_val[31] ^ rt_val[31]);
                        neg_rem_reg <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= MD_RUN;
                     end
                     MD_DIV, MD_DIVU: begin
                        if (rt_val == '0) begin
                           // Divide by zero resolves immediately
                           hi_reg   <= rs_val;
                           lo_reg   <= '1;
                           done_reg <= 1'b1;
                        end else begin
                           acc_reg     <= {32'd0, opnd_abs[31:0]};
                           mcand_reg   <= {32'd0, opnd_abs[63:32]};
                           mplier_reg  <= '0;
                           is_div_reg  <= 1'b1;
                           neg_res_reg <= op_signed & (rs_val[31] ^ rt_val[31]);
                           neg_rem_reg <= op_signed & rs_val[31];
                           cnt_reg     <= '0;
                           state_reg   <= MD_RUN;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            MD_RUN: begin
               acc_reg    <= acc_next;
               mplier_reg <= mplier_reg >> 1;
               if (!is_div_reg)
                  mcand_reg <= mcand_reg << 1;
               cnt_reg <= cnt_reg + 1'b1;
               if (last_step) begin
                  hi_reg    <= res_fixed[63:32];
                  lo_reg    <= res_fixed[31:0];
                  cnt_reg   <= '0;
                  done_reg  <= 1'b1;
                  state_reg <= MD_IDLE;
               end
            end
            default: state_reg <= MD_IDLE;
         endcase
      end
   end

   assign busy = (state_reg == MD_RUN);
   assign done = done_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases followed by
// randomized ops against an arithmetic reference model of HI/LO.
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          checks;
   int          errors;
   logic [31:0] model_hi;
   logic [31:0] model_lo;
   bit          allow_busy_start;

   ex_muldiv_unit dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hazard unit contract: no start while busy, except where deliberately injected
   always @(posedge clk) begin
      if (reset && !allow_busy_start)
         assert (!(start && busy)) else $error("hazard violation: start while busy");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: HI/LO after the op, RUN length, and whether done pulses
   task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int cyc, output bit dn);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      logic [63:0] t;
      logic [31:0] m;
      sa  = $signed(a);
      sb  = $signed(b);
      cyc = 0;
      dn  = 1'b0;
      m   = b;
      case (o)
         MD_MULT, MD_MULTU: begin
            if (o == MD_MULT) begin
               t = sa * sb;
               p = t;
               if (b[31]) m = -b;
            end else begin
               p = {32'd0, a} * {32'd0, b};
            end
            model_hi = p[63:32];
            model_lo = p[31:0];
            dn  = 1'b1;
            cyc = 32;
`ifdef MULDIV_EARLY_OUT_EN
            cyc = 1;
            for (int k = 0; k < 32; k++)
               if (m[k]) cyc = k + 1;
`endif
         end
         MD_DIV, MD_DIVU: begin
            dn = 1'b1;
            if (b == 32'd0) begin
               model_hi = a;
               model_lo = 32'hFFFF_FFFF;
            end else begin
               cyc = 32;
               if (o == MD_DIV) begin
                  sq = sa / sb;
                  sr = sa % sb;
                  t  = sq;
                  model_lo = t[31:0];
                  t  = sr;
                  model_hi = t[31:0];
               end else begin
                  model_lo = a / b;
                  model_hi = a % b;
               end
            end
         end
         MD_MTHI: model_hi = a;
         MD_MTLO: model_lo = a;
         default: ;
      endcase
   endtask

   // Issue one op at the current negedge and follow it to completion.
   // chain: leave the bench at the done cycle so the next op issues back-to-back.
   // intrude: inject an illegal start mid-run, which must be ignored.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit chain, input bit intrude);
      int cycles;
      int exp_cyc;
      bit exp_dn;
      model_op(o, a, b, exp_cyc, exp_dn);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(negedge clk);
      start  = 1'b0;
      cycles = 0;
      while (busy && cycles < 100) begin
         cycles++;
         if (intrude && cycles == 5) begin
            allow_busy_start = 1'b1;
            start  = 1'b1;
            op     = MD_MTHI;
            rs_val = 32'hDEAD_BEEF;
            rt_val = 32'h0;
         end
         @(negedge clk);
         start = 1'b0;
         allow_busy_start = 1'b0;
      end
      check("busy_cycles", 64'(cycles), 64'(exp_cyc));
      check("done", {63'd0, done}, {63'd0, exp_dn});
      check("hi", {32'd0, hi}, {32'd0, model_hi});
      check("lo", {32'd0, lo}, {32'd0, model_lo});
      $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d done=%0b",
               o, a, b, hi, lo, cycles, done);
      if (exp_dn && !chain) begin
         @(negedge clk);
         check("done_pulse", {63'd0, done}, 64'd0);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      allow_busy_start = 1'b0;
      model_hi = '0;
      model_lo = '0;
      reset  = 1'b0;
      start  = 1'b0;
      op     = '0;
      rs_val = '0;
      rt_val = '0;

      repeat (2) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Directed cases
      do_op(MD_MULT,  32'hFFFF_FFFE, 32'd3,         1'b0, 1'b0);
      do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_op(MD_MULTU, 32'h1234_5678, 32'd1,         1'b0, 1'b0);
      do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
      do_op(MD_DIVU,  32'd100,       32'd7,         1'b0, 1'b0);
      do_op(MD_DIV,   32'd5,         32'd0,         1'b0, 1'b0);
      do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      do_op(MD_MTHI,  32'h1234_5678, 32'd0,         1'b0, 1'b0);
      do_op(MD_MTLO,  32'h9ABC_DEF0, 32'd0,         1'b0, 1'b0);
      do_op(MD_MULT,  32'h0000_7FFF, 32'hFFFF_8001, 1'b0, 1'b1);
      do_op(3'd6,     32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
      // Back-to-back: second op issued in the done cycle of the first
      do_op(MD_DIVU,  32'hFFFF_FFFF, 32'd16,        1'b1, 1'b0);
      do_op(MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

      // Reset in the middle of a DIV aborts it with HI/LO cleared
      start  = 1'b1;
      op     = MD_DIV;
      rs_val = 32'h7654_3210;
      rt_val = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hi", {32'd0, hi}, 64'd0);
      check("abort_lo", {32'd0, lo}, 64'd0);
      model_hi = '0;
      model_lo = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_op(MD_MULTU, 32'd3, 32'd4, 1'b0, 1'b0);

      // Randomized ops, including reserved codes and zero divisors
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  o;
         logic [31:0] a;
         logic [31:0] b;
         o = 3'($urandom_range(0, 7));
         a = pick_operand();
         b = pick_operand();
         do_op(o, a, b, 1'($urandom_range(0, 1)), 1'b0);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
